// File: rtl/mem_arb_pkg.sv
// ============================================================================
// Module   : mem_arb_pkg
// Brief    : Shared owner and mode encodings for the unified-memory arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_arb_pkg;

   localparam logic [1:0] OWN_I = 2'd0;
   localparam logic [1:0] OWN_D = 2'd1;
   localparam logic [1:0] OWN_L = 2'd2;

   typedef enum logic [1:0] {
      MODE_RUN   = 2'd0,
      MODE_DRAIN = 2'd1,
      MODE_LOAD  = 2'd2
   } mode_t;

   // True when a pipe entry is a live read belonging to the given owner.
   function automatic logic owns_read(input logic v, input logic [1:0] own,
                                      input logic [1:0] who);
      return v && (own == who);
   endfunction

endpackage

`default_nettype wire

// File: rtl/mem_arb_owner_pipe.sv
// ============================================================================
// Module   : mem_arb_owner_pipe
// Brief    : RD_LAT-deep {valid, owner} shift register tracking in-flight reads.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_arb_owner_pipe
   import mem_arb_pkg::*;
#(
   parameter int RD_LAT = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       i_push_valid,
   input  logic [1:0] i_push_owner,
   output logic       o_tail_valid,
   output logic [1:0] o_tail_owner,
   output logic       o_empty
);

   logic [RD_LAT-1:0] r_valid;
   logic [1:0]        r_owner [RD_LAT];
   logic              w_pending;

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_valid <= '0;
         for (int k = 0; k < RD_LAT; k++) begin
            r_owner[k] <= OWN_I;
         end
      end else begin
         r_valid[0] <= i_push_valid;
         r_owner[0] <= i_push_owner;
         for (int k = 1; k < RD_LAT; k++) begin
            r_valid[k] <= r_valid[k-1];
            r_owner[k] <= r_owner[k-1];
         end
      end
   end

   // The tail returns its data this cycle, so only the stages ahead of it
   // still count as in flight once the current edge has passed.
   always_comb begin
      w_pending = 1'b0;
      for (int k = 0; k < RD_LAT - 1; k++) begin
         w_pending = w_pending | r_valid[k];
      end
   end

   assign o_tail_valid = r_valid[RD_LAT-1];
   assign o_tail_owner = r_owner[RD_LAT-1];
   assign o_empty      = ~w_pending;

endmodule

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// ============================================================================
// Module   : mem_port_arbiter
// Brief    : Fixed-priority, starvation-guarded arbiter sharing one block RAM
//            between fetch, data and (with MEM_ARB_LOADER_EN) a program loader.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W     = 14,
   parameter int DATA_W     = 32,
   parameter int RD_LAT     = 1,
   parameter int STARVE_MAX = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                i_req,
   input  logic [ADDR_W-1:0]   i_addr,
   output logic                i_gnt,
   output logic                i_rvalid,
   output logic [DATA_W-1:0]   i_rdata,
   input  logic                d_req,
   input  logic                d_we,
   input  logic [DATA_W/8-1:0] d_be,
   input  logic [ADDR_W-1:0]   d_addr,
   input  logic [DATA_W-1:0]   d_wdata,
   output logic                d_gnt,
   output logic                d_rvalid,
   output logic [DATA_W-1:0]   d_rdata,
`ifdef MEM_ARB_LOADER_EN
   input  logic                l_active,
   input  logic                l_req,
   input  logic [ADDR_W-1:0]   l_addr,
   input  logic [DATA_W-1:0]   l_wdata,
   output logic                l_gnt,
`endif
   output logic                cpu_hold,
   output logic                mem_en,
   output logic [DATA_W/8-1:0] mem_we,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [DATA_W-1:0]   mem_wdata,
   input  logic [DATA_W-1:0]   mem_rdata
);

   localparam int CNT_W = $clog2(STARVE_MAX + 1);
   localparam logic [CNT_W-1:0] c_starve_max = CNT_W'(STARVE_MAX);

   mode_t               w_mode;
   logic                w_mode_chg;
   logic [CNT_W-1:0]    r_starve;
   logic                w_i_gnt;
   logic                w_d_gnt;
   logic                w_l_gnt;
   logic                w_l_req;
   logic [DATA_W/8-1:0] w_mem_we;
   logic [ADDR_W-1:0]   w_mem_addr;
   logic [DATA_W-1:0]   w_mem_wdata;
   logic                w_push_valid;
   logic [1:0]          w_push_owner;
   logic                w_tail_valid;
   logic [1:0]          w_tail_owner;
   logic                w_pipe_empty;

`ifdef MEM_ARB_LOADER_EN
   mode_t r_mode;
   logic  r_cpu_hold;

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_mode     <= MODE_RUN;
         r_cpu_hold <= 1'b0;
      end else begin
         case (r_mode)
            MODE_RUN: begin
               if (l_active) begin
                  r_mode     <= MODE_DRAIN;
                  r_cpu_hold <= 1'b1;
               end
            end
            MODE_DRAIN: begin
               if (!l_active) begin
                  r_mode     <= MODE_RUN;
                  r_cpu_hold <= 1'b0;
               end else if (w_pipe_empty) begin
                  r_mode     <= MODE_LOAD;
               end
            end
            MODE_LOAD: begin
               if (!l_active) begin
                  r_mode     <= MODE_RUN;
                  r_cpu_hold <= 1'b0;
               end
            end
            default: begin
               r_mode     <= MODE_RUN;
               r_cpu_hold <= 1'b0;
            end
         endcase
      end
   end

   // Mirrors the FSM transition conditions so the starvation counter can clear.
   always_comb begin
      w_mode_chg = 1'b0;
      case (r_mode)
         MODE_RUN:   w_mode_chg = l_active;
         MODE_DRAIN: w_mode_chg = !l_active || w_pipe_empty;
         MODE_LOAD:  w_mode_chg = !l_active;
         default:    w_mode_chg = 1'b1;
      endcase
   end

   assign w_mode   = r_mode;
   assign w_l_req  = l_req;
   assign cpu_hold = r_cpu_hold;
   assign l_gnt    = w_l_gnt;
`else
   assign w_mode     = MODE_RUN;
   assign w_mode_chg = 1'b0;
   assign w_l_req    = 1'b0;
   assign cpu_hold   = 1'b0;
`endif

   always_comb begin
      w_i_gnt = 1'b0;
      w_d_gnt = 1'b0;
      w_l_gnt = 1'b0;
      if (rst) begin
         if (w_mode == MODE_RUN) begin
            if (d_req && (r_starve < c_starve_max)) begin
               w_d_gnt = 1'b1;
            end else if (i_req) begin
               w_i_gnt = 1'b1;
            end else if (d_req) begin
               w_d_gnt = 1'b1;
            end
         end else if (w_mode == MODE_LOAD) begin
            w_l_gnt = w_l_req;
         end
      end
   end

   always_comb begin
      w_mem_we    = '0;
      w_mem_addr  = '0;
      w_mem_wdata = '0;
      if (w_d_gnt) begin
         w_mem_addr  = d_addr;
         w_mem_wdata = d_wdata;
         w_mem_we    = d_we ? d_be : '0;
      end else if (w_i_gnt) begin
         w_mem_addr  = i_addr;
      end
`ifdef MEM_ARB_LOADER_EN
      else if (w_l_gnt) begin
         w_mem_addr  = l_addr;
         w_mem_wdata = l_wdata;
         w_mem_we    = '1;
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_starve <= '0;
      end else if (w_mode_chg || !i_req || w_i_gnt) begin
         r_starve <= '0;
      end else if (w_d_gnt && (r_starve != c_starve_max)) begin
         r_starve <= r_starve + CNT_W'(1);
      end
   end

   assign w_push_valid = w_i_gnt || (w_d_gnt && !d_we);
   assign w_push_owner = w_d_gnt ? OWN_D : OWN_I;

   mem_arb_owner_pipe #(
      .RD_LAT (RD_LAT)
   ) u_owner_pipe (
      .clk          (clk),
      .rst          (rst),
      .i_push_valid (w_push_valid),
      .i_push_owner (w_push_owner),
      .o_tail_valid (w_tail_valid),
      .o_tail_owner (w_tail_owner),
      .o_empty      (w_pipe_empty)
   );

   // Returns are gated by reset so a read caught by reset never surfaces.
   assign i_rvalid  = rst && owns_read(w_tail_valid, w_tail_owner, OWN_I);
   assign d_rvalid  = rst && owns_read(w_tail_valid, w_tail_owner, OWN_D);
   assign i_rdata   = i_rvalid ? mem_rdata : '0;
   assign d_rdata   = d_rvalid ? mem_rdata : '0;

   assign i_gnt     = w_i_gnt;
   assign d_gnt     = w_d_gnt;
   assign mem_en    = w_i_gnt || w_d_gnt || w_l_gnt;
   assign mem_we    = w_mem_we;
   assign mem_addr  = w_mem_addr;
   assign mem_wdata = w_mem_wdata;

endmodule

`default_nettype wire
